serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block able to accept operands.
REQ-006 op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  WIDTH  result bits.
REQ-012 cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow.
REQ-014 busy  output  1  high in RUN state.

Function
REQ-015 Single bit-serial datapath: exactly one full_adder instance computes all WIDTH result bits, one bit per clk, LSB first.
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on in_valid&in_ready; RUN->DONE after WIDTH bit cycles; DONE->IDLE on out_valid&out_ready.
REQ-017 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; busy = 1 only in RUN.
REQ-018 On acceptance: latch a into A shift register, b (op=0) or ~b (op=1) into B shift register, carry flop = op, bit counter = 0.
REQ-019 Each RUN cycle: full_adder inputs = A[0], B[0], carry flop; sum bit shifted into result register MSB end; A, B shift right; carry flop takes adder carry; counter increments.
REQ-020 Counter width = $clog2(WIDTH); RUN exits on the cycle counter == WIDTH-1; counter returns to 0, no wrap beyond.
REQ-021 Latency: acceptance on edge T; out_valid rises after edge T+WIDTH; throughput one operation per WIDTH+2 cycles minimum.
REQ-022 cout = final carry flop; ovf = carry into MSB XOR carry out of MSB, captured on the last bit cycle.
REQ-023 sum, cout, ovf stable throughout DONE regardless of a, b, op, in_valid changes.
REQ-024 in_valid while not in IDLE ignored; no queuing of operands.
REQ-025 DONE with out_ready low: hold indefinitely; DONE with out_ready high: next cycle IDLE, new operands accepted no earlier than that cycle.
REQ-026 Arithmetic modulo 2^WIDTH; a, b treated identically for signed/unsigned, only ovf interprets signed.

Reset
REQ-027 rst_n low at a rising edge: state = IDLE, counter = 0, carry flop = 0, A/B/result registers = 0.
REQ-028 Reset values: in_ready = 1 after reset release, out_valid = 0, busy = 0, sum = 0, cout = 0, ovf = 0.
REQ-029 Reset in RUN or DONE aborts the operation; partial result discarded, no out_valid produced.

Structure
REQ-030 Package serial_add_pkg holds state enum (IDLE, RUN, DONE) and op encoding constants OP_ADD = 0, OP_SUB = 1.
REQ-031 One sub-module: existing full_adder (inputs a, b, c; outputs sum, carry), instantiated once; all other logic in serial_add_ctrl.
REQ-032 No combinational path from in_valid or out_ready to any output except none; all outputs driven from registers or state decode.

Verification (WIDTH = 8)
REQ-033 add 8'h0F + 8'h01, out_ready = 1 -> out_valid after 8 cycles, sum = 8'h10, cout = 0, ovf = 0.
REQ-034 add 8'hFF + 8'h01 -> sum = 8'h00, cout = 1, ovf = 0; add 8'h7F + 8'h01 -> sum = 8'h80, cout = 0, ovf = 1.
REQ-035 sub 8'h05 - 8'h07 -> sum = 8'hFE, cout = 0, ovf = 0; sub 8'h80 - 8'h01 -> sum = 8'h7F, cout = 1, ovf = 1.
REQ-036 Backpressure: out_ready held low 10 cycles with a, b, op, in_valid toggling -> out_valid stays 1, sum/cout/ovf unchanged, in_ready stays 0.
REQ-037 Reset mid-RUN at bit 4 -> next cycle state IDLE, in_ready = 1, out_valid = 0, sum = 0; following add 8'h22 + 8'h11 -> sum = 8'h33.
REQ-038 Back-to-back: in_valid held high with two operand sets -> second accepted exactly one cycle after first result handshake; both results correct.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract controller: FSM states and op codes.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full adder processes operands LSB first, one bit per clock,
// with a ready/valid handshake on each side.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit_c;

  assign last_bit_c = (cnt == CW'(WIDTH - 1));
  assign sum        = res;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (cy),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Subtraction is a + ~b + 1: the +1 enters through the initial carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cy        <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= (op == OP_SUB) ? ~b : b;
            cy       <= op;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          res  <= {fa_sum, res[WIDTH-1:1]};
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          cy   <= fa_carry;
          if (last_bit_c) begin
            // Carry into the MSB is the flop value on this final bit.
            cnt       <= '0;
            cout      <= fa_carry;
            ovf       <= cy ^ fa_carry;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vectors, random operations
// against an integer-arithmetic reference, backpressure, mid-run reset and back-to-back.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int total;
  int bad;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic; returns {cout, ovf, sum}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                             input logic xop);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [W-1:0] res;
    ua = int'(xa);
    ub = int'(xb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (xop == 1'b0) begin
      r = ua + ub;
      c = (r >= 256);
      s = sa + sb;
    end else begin
      r = ua - ub + 256;
      c = (ua >= ub);
      s = sa - sb;
    end
    res = W'(r % 256);
    v = (s > 127) || (s < -128);
    return {c, v, res};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand set, waits for the result, then takes it.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xop,
                        output logic [W+1:0] got, output int lat);
    int g;
    g = 0;
    a = xa;
    b = xb;
    op = xop;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    got = {cout, ovf, sum};
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL reset_flags: got ready/valid/busy=%b want 100", {in_ready, out_valid, busy});
    end
    total++;
    if ({cout, ovf, sum} !== 10'h000) begin
      bad++;
      $display("FAIL reset_result: got cout=%b ovf=%b sum=%h want 0 0 00", cout, ovf, sum);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [W-1:0] vb [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
    logic         vo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] ve [5] = '{{2'b00, 8'h10}, {2'b10, 8'h00}, {2'b01, 8'h80},
                             {2'b00, 8'hFE}, {2'b11, 8'h7F}};
    logic [W+1:0] got;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vo[i], got, lat);
      total++;
      if (got !== ve[i]) begin
        bad++;
        $display("FAIL directed_%0d: got cout/ovf/sum=%b/%b/%h want %b/%b/%h", i,
                 got[W+1], got[W], got[W-1:0], ve[i][W+1], ve[i][W], ve[i][W-1:0]);
      end
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL directed_latency_%0d: got %0d want 8", i, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic ro;
    logic [W+1:0] got, exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      ro = 1'($urandom_range(0, 1));
      exp = ref_model(ra, rb, ro);
      run_op(ra, rb, ro, got, lat);
      total++;
      if (got !== exp || lat !== 8) begin
        bad++;
        $display("FAIL random_%0d: a=%h b=%h op=%b got %b/%b/%h lat=%0d want %b/%b/%h lat=8",
                 i, ra, rb, ro, got[W+1], got[W], got[W-1:0], lat,
                 exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp;
    int lat;
    int errs;
    exp = ref_model(8'hC3, 8'h5A, 1'b1);
    a = 8'hC3;
    b = 8'h5A;
    op = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL bp_latency: got %0d want 8", lat);
    end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      op = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      step();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, ovf, sum} !== exp) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid=%b ready=%b res=%h want 1 0 %h",
                 i, out_valid, in_ready, {cout, ovf, sum}, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W+1:0] got;
    int lat;
    int seen;
    a = 8'hAB;
    b = 8'h37;
    op = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrun_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) begin
      bad++;
      $display("FAIL midrun_reset: got ready=%b valid=%b busy=%b sum=%h want 1 0 0 00",
               in_ready, out_valid, busy, sum);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrun_no_valid: got %0d valid cycles want 0", seen);
    end
    run_op(8'h22, 8'h11, 1'b0, got, lat);
    total++;
    if (got !== {2'b00, 8'h33} || lat !== 8) begin
      bad++;
      $display("FAIL midrun_next_op: got res=%h lat=%0d want 033 lat=8", got, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] e1, e2;
    int lat;
    e1 = ref_model(8'h9C, 8'h64, 1'b0);
    e2 = ref_model(8'h10, 8'h2F, 1'b1);
    a = 8'h9C;
    b = 8'h64;
    op = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    a = 8'h10;
    b = 8'h2F;
    op = 1'b1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    total++;
    if (lat !== 8 || {cout, ovf, sum} !== e1) begin
      bad++;
      $display("FAIL b2b_first: got res=%h lat=%0d want %h lat=8", {cout, ovf, sum}, lat, e1);
    end
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_handshake: got ready=%b valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b ready=%b want 1 0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    total++;
    if (lat !== 8 || {cout, ovf, sum} !== e2) begin
      bad++;
      $display("FAIL b2b_second: got res=%h lat=%0d want %h lat=8", {cout, ovf, sum}, lat, e2);
    end
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
